irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  External interrupt controller directly upstream of the coprocessor-0 exception unit.
//  Synchronises N asynchronous interrupt lines, latches edges into a pending register, and masks them.
//  Selects the highest-priority request and drives the single interrupt-request level to coprocessor 0.
//  Holds that request until coprocessor 0 takes it, then stays in service until ERET.
// PARAMETERS
//  N_IRQ      8        number of external lines, 1..32; line 0 = highest priority
//  BASE_ADDR  32'h80   byte address of first register; registers at BASE+0x0/0x8/0x10/0x18
// PORTS
//  i_clk        in   1      single clock, all state on rising edge
//  i_rst        in   1      asynchronous, active-high reset
//  i_irq        in   N_IRQ  raw external interrupt lines, asynchronous
//  i_we         in   1      register write strobe from datapath
//  i_addr       in   32     register byte address
//  i_data       in   32     write data
//  o_data       out  32     read data, combinational from i_addr; 0 for unmapped addresses
//  i_int_taken  in   1      coprocessor 0 accepted the interrupt this cycle (its o_interrupt)
//  i_eret       in   1      ERET executed; ends service
//  o_interrupt  out  1      interrupt request level, wired to coprocessor 0 i_interrupt
//  o_irq_id     out  5      index of the claimed or requesting line; valid when state != IDLE
// BEHAVIOUR
//  Reset (async, immediate): sync flops, pending, mask and id cleared; FSM = IDLE.
//  Reset outputs: o_interrupt = 0, o_irq_id = 0.
//  Sync: 2-FF synchroniser per line, plus a third flop for edge detect.
//   Rise sampled at edge k -> pending bit set at edge k+2 -> o_interrupt = 1 after edge k+3.
//  Registers:
//   PEND BASE+0x0: reads pending; write-1-to-clear.
//   MASK BASE+0x8: read/write; 1 = enabled.
//   ID   BASE+0x10: read-only, {27'b0, o_irq_id}.
//  Width: registers are 32 bit; bits >= N_IRQ read 0 and ignore writes.
//  Request: req = pending & mask; winner = lowest set index (priority encoder).
//  FSM (registered, o_interrupt = (state == REQ)):
//   IDLE: |req -> REQ; latch id = winner.
//   REQ: i_int_taken -> SVC; clear pending[id] (claim). The id is frozen while in REQ.
//        If i_eret or mask[id] cleared before take -> IDLE; pending[id] is kept.
//   SVC: i_eret -> IDLE; new requests wait. Re-request is possible the cycle after IDLE.
//  Simultaneous events on a pending bit:
//   new edge plus W1C or claim in the same cycle -> set wins; bit stays 1.
//   W1C of pending[id] while in REQ -> IDLE next cycle; no take.
//  Wrap: an edge on an already-pending line is absorbed; there is no counting.
//  Reset asserted mid-REQ/SVC: outputs drop immediately; all pending edges are lost.
// CONFIGURATION
//  IRQ_LEVEL_EN defined:
//   Adds TRIG register at BASE+0x18, read/write, 1 = level-sensitive line.
//   A level line sets pending each cycle its synchronised input is 1. W1C only succeeds once the input is low.
//   Claim clears the bit, but it re-sets next cycle if the input is still high.
//  IRQ_LEVEL_EN undefined:
//   All lines are edge-triggered. BASE+0x18 reads 0 and ignores writes.
// STRUCTURE
//  Shared package irq_pkg:
//   FSM state encoding IDLE=2'd0, REQ=2'd1, SVC=2'd2.
//   Register offsets OFF_PEND/OFF_MASK/OFF_ID/OFF_TRIG.
//   IRQ_ID_W = 5.
//  One sub-module irq_sync: per-line 2-FF synchroniser plus edge-detect flop.
//   Outputs sync level and a 1-cycle rise pulse. Instantiated with width N_IRQ.
//  Priority encoder and FSM stay inline in irq_ctrl.
// TESTING
//  T1 reset: assert i_rst mid-SVC with PEND=0x05 -> o_interrupt=0 immediately; PEND/MASK/ID read 0 after release.
//  T2 latency: MASK=0x08; pulse i_irq[3] -> PEND=0x08 at k+2; o_interrupt=1 after k+3.
//   Then i_int_taken -> PEND=0x00, ID=3; i_eret -> IDLE.
//  T3 priority: MASK=0xFF; lines 6 and 2 rise in the same cycle.
//   ID=2 first; after take and eret, ID=6.
//  T4 mask: MASK=0x00, pulse line 1 -> PEND=0x02, o_interrupt stays 0.
//   Then write MASK=0x02 -> o_interrupt=1 one cycle later.
//  T5 collisions:
//   W1C of 0x01 in the same cycle as a new edge on line 0 -> PEND[0]=1.
//   W1C of the claimed id while in REQ -> IDLE, no take.
//  T6 IRQ_LEVEL_EN: TRIG=0x10, hold i_irq[4] high through take and eret -> immediate re-request; ID=4.
//   Without the macro, TRIG reads 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the external interrupt controller: FSM encoding,
// register offsets and the id width used on the coprocessor-0 side.
package irq_pkg;

  localparam int IRQ_ID_W = 5;

  localparam logic [31:0] OFF_PEND = 32'h0000_0000;
  localparam logic [31:0] OFF_MASK = 32'h0000_0008;
  localparam logic [31:0] OFF_ID   = 32'h0000_0010;
  localparam logic [31:0] OFF_TRIG = 32'h0000_0018;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

  // One-hot select of a line index across the full 32-bit register width.
  function automatic logic [31:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    return 32'd1 << id;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-line two-flop synchroniser followed by an edge-detect flop; provides
// the synchronised level and a one-cycle rising-edge pulse.
module irq_sync #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_level,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;
  logic [W-1:0] prev_r;

  // Synchroniser chain plus delayed copy for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_r <= '0;
      sync_r <= '0;
      prev_r <= '0;
    end else begin
      meta_r <= i_async;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign o_level = sync_r;
  assign o_rise  = sync_r & ~prev_r;

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller feeding the coprocessor-0 interrupt input.
// Optional level-sensitive lines and TRIG register: define IRQ_LEVEL_EN.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          N_IRQ     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0080
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_IRQ-1:0]    i_irq,
  input  logic                i_we,
  input  logic [31:0]         i_addr,
  input  logic [31:0]         i_data,
  output logic [31:0]         o_data,
  input  logic                i_int_taken,
  input  logic                i_eret,
  output logic                o_interrupt,
  output logic [IRQ_ID_W-1:0] o_irq_id
);

  logic [N_IRQ-1:0]    level_s;
  logic [N_IRQ-1:0]    rise_s;
  logic [N_IRQ-1:0]    pend_r;
  logic [N_IRQ-1:0]    mask_r;
  logic [N_IRQ-1:0]    trig_s;
  logic [N_IRQ-1:0]    pend_nxt_s;
  logic [N_IRQ-1:0]    mask_nxt_s;
  logic [N_IRQ-1:0]    set_s;
  logic [N_IRQ-1:0]    clr_s;
  logic [N_IRQ-1:0]    claim_s;
  logic [N_IRQ-1:0]    req_s;
  logic [N_IRQ-1:0]    id_sel_s;
  logic [31:0]         id_hot32_s;
  logic [31:0]         rd_s;
  logic [IRQ_ID_W-1:0] id_r;
  logic [IRQ_ID_W-1:0] id_nxt_s;
  logic [IRQ_ID_W-1:0] winner_s;
  logic                int_r;
  logic                wr_pend_s;
  logic                wr_mask_s;
  logic                data_unused_s;
  irq_state_e          state_r;
  irq_state_e          state_nxt_s;

  irq_sync #(.W(N_IRQ)) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_irq),
    .o_level (level_s),
    .o_rise  (rise_s)
  );

  assign wr_pend_s     = i_we && (i_addr == (BASE_ADDR + OFF_PEND));
  assign wr_mask_s     = i_we && (i_addr == (BASE_ADDR + OFF_MASK));
  assign id_hot32_s    = id_onehot(id_r);
  assign id_sel_s      = id_hot32_s[N_IRQ-1:0];
  assign req_s         = pend_r & mask_r;
  // Write-data bits above N_IRQ are intentionally ignored.
  assign data_unused_s = ^i_data;

`ifdef IRQ_LEVEL_EN
  logic [N_IRQ-1:0] trig_r;
  logic             wr_trig_s;

  assign wr_trig_s = i_we && (i_addr == (BASE_ADDR + OFF_TRIG));
  assign trig_s    = trig_r;

  // Trigger-mode register: 1 selects level sensitivity for that line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      trig_r <= '0;
    end else if (wr_trig_s) begin
      trig_r <= i_data[N_IRQ-1:0];
    end else begin
      trig_r <= trig_r;
    end
  end
`else
  assign trig_s = '0;
`endif

  // Pending/mask next state; a set from the line always beats a clear.
  always_comb begin
    claim_s    = ((state_r == REQ) && i_int_taken) ? id_sel_s : '0;
    // A claimed level line drops for one cycle before its level re-sets it.
    set_s      = rise_s | (level_s & trig_s & ~claim_s);
    clr_s      = (wr_pend_s ? i_data[N_IRQ-1:0] : '0) | claim_s;
    pend_nxt_s = (pend_r & ~clr_s) | set_s;
    mask_nxt_s = wr_mask_s ? i_data[N_IRQ-1:0] : mask_r;
  end

  // Priority encoder: the lowest-index requesting line wins.
  always_comb begin
    winner_s = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      winner_s = req_s[i] ? IRQ_ID_W'(i) : winner_s;
    end
  end

  // Request FSM next state and id latch.
  always_comb begin
    state_nxt_s = state_r;
    id_nxt_s    = id_r;
    case (state_r)
      IDLE: begin
        if (|req_s) begin
          state_nxt_s = REQ;
          id_nxt_s    = winner_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        // Withdraw the request as soon as its line is cleared or masked off.
        if (i_int_taken) begin
          state_nxt_s = SVC;
        end else if (i_eret || ((pend_nxt_s & mask_nxt_s & id_sel_s) == '0)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      SVC: begin
        if (i_eret) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SVC;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, id, registered request level and pending/mask registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
      id_r    <= '0;
      int_r   <= 1'b0;
      pend_r  <= '0;
      mask_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      id_r    <= id_nxt_s;
      int_r   <= (state_nxt_s == REQ);
      pend_r  <= pend_nxt_s;
      mask_r  <= mask_nxt_s;
    end
  end

  // Register read mux; unmapped addresses read zero.
  always_comb begin
    rd_s = 32'd0;
    case (i_addr)
      BASE_ADDR + OFF_PEND: rd_s[N_IRQ-1:0]    = pend_r;
      BASE_ADDR + OFF_MASK: rd_s[N_IRQ-1:0]    = mask_r;
      BASE_ADDR + OFF_ID:   rd_s[IRQ_ID_W-1:0] = id_r;
`ifdef IRQ_LEVEL_EN
      BASE_ADDR + OFF_TRIG: rd_s[N_IRQ-1:0]    = trig_s;
`endif
      default:              rd_s               = 32'd0;
    endcase
  end

  assign o_data      = rd_s;
  assign o_interrupt = int_r;
  assign o_irq_id    = id_r;

endmodule
